// File: rtl/aes_stream_loader.sv
// aes_stream_loader: stream adapter for a combinational AES-128 encryption core.
// It collects a key and four 32-bit plaintext words, then holds block and key
// stable on the core inputs for SETTLE_CYCLES. After that it captures the core
// result and streams it out as four 32-bit words. Only one block is in flight,
// and the input and output phases never overlap.
module aes_stream_loader #(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         key_valid,
    output logic         key_ready,
    input  logic [127:0] key_in,
    input  logic         s_valid,
    output logic         s_ready,
    input  logic [31:0]  s_data,
    output logic [127:0] core_data,
    output logic [127:0] core_key,
    input  logic [127:0] core_result,
    output logic         m_valid,
    input  logic         m_ready,
    output logic [31:0]  m_data,
    output logic         busy,
    output logic         key_loaded
);

    localparam int SCW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [SCW-1:0] SCNT_LAST = SCW'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {
        COLLECT,
        SETTLE,
        DRAIN
    } state_t;

    state_t         state;
    state_t         state_next;
    logic [1:0]     wcnt;
    logic [1:0]     ocnt;
    logic [SCW-1:0] scnt;
    logic [127:0]   data_reg;
    logic [127:0]   key_reg;
    logic [127:0]   result_reg;

    logic s_fire;
    logic key_fire;
    logic m_fire;

    assign s_fire   = s_valid & s_ready;
    assign key_fire = key_valid & key_ready;
    assign m_fire   = m_valid & m_ready;

    assign core_data = data_reg;
    assign core_key  = key_reg;
    assign m_data    = result_reg[127:96];

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= COLLECT;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode and handshake outputs.
    always_comb begin
        state_next = state;
        key_ready  = 1'b0;
        s_ready    = 1'b0;
        m_valid    = 1'b0;
        busy       = 1'b0;
        case (state)
            COLLECT: begin
                // The key may only change between blocks, never mid-block.
                key_ready = (wcnt == 2'd0);
                s_ready   = key_loaded;
                if (s_valid && key_loaded && (wcnt == 2'd3)) begin
                    state_next = SETTLE;
                end
            end
            SETTLE: begin
                busy = 1'b1;
                if (scnt == SCNT_LAST) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                busy    = 1'b1;
                m_valid = 1'b1;
                if (m_ready && (ocnt == 2'd3)) begin
                    state_next = COLLECT;
                end
            end
            default: begin
                state_next = COLLECT;
            end
        endcase
    end

    // Datapath: key and block assembly, settle counter, result capture and drain shift.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wcnt       <= '0;
            ocnt       <= '0;
            scnt       <= '0;
            data_reg   <= '0;
            key_reg    <= '0;
            result_reg <= '0;
            key_loaded <= 1'b0;
        end else begin
            // A key and the first word can land on the same edge.
            // The block then uses the new key.
            if (key_fire) begin
                key_reg    <= key_in;
                key_loaded <= 1'b1;
            end
            if (state == COLLECT && s_fire) begin
                data_reg <= {data_reg[95:0], s_data};
                wcnt     <= wcnt + 2'd1;
                if (wcnt == 2'd3) begin
                    scnt <= '0;
                end
            end
            if (state == SETTLE) begin
                scnt <= scnt + 1'b1;
                if (scnt == SCNT_LAST) begin
                    result_reg <= core_result;
                    ocnt       <= '0;
                end
            end
            if (state == DRAIN && m_fire) begin
                result_reg <= {result_reg[95:0], 32'h0};
                ocnt       <= ocnt + 2'd1;
            end
        end
    end

endmodule
